// File: rtl/wb_bram_ctrl.sv
// wb_bram_ctrl: Wishbone classic slave driving one synchronous BRAM port, with base-window decode.
// Latency: write terminates 1 cycle after strobe, read READ_LATENCY+1 cycles; at most one access per 2 cycles.
// Backpressure: master is held by withholding ack/err; dropping wb_cyc_i aborts a read or suppresses termination.
module wb_bram_ctrl #(
   parameter int          DATA_WIDTH   = 32,
   parameter int          ADDR_WIDTH   = 18,
   parameter int          READ_LATENCY = 1,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter bit          ERR_ENABLE   = 1'b1
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    wb_cyc_i,
   input  logic                    wb_stb_i,
   input  logic                    wb_we_i,
   input  logic [31:0]             wb_adr_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic                    wb_ack_o,
   output logic                    wb_err_o,
   output logic                    ram_en,
   output logic [DATA_WIDTH/8-1:0] ram_wea,
   output logic [ADDR_WIDTH-1:0]   ram_addr,
   output logic [DATA_WIDTH-1:0]   ram_data_o,
   input  logic [DATA_WIDTH-1:0]   ram_data_i
);

   localparam int SEL_W     = DATA_WIDTH / 8;
   localparam int BYTE_BITS = $clog2(SEL_W);
   localparam int WIN_LSB   = ADDR_WIDTH + BYTE_BITS;
   // Counter preload: remaining RD_WAIT cycles before ram_data_i is valid.
   localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, RD_WAIT, ACK, ERR} state_t;

   state_t                state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] dat_q;
   logic                  cap;
   logic                  en_c, ack_c, err_c;
   logic [SEL_W-1:0]      wea_c;
   logic [ADDR_WIDTH-1:0] addr_c;

   logic                  req;
   logic                  in_win;
   logic [ADDR_WIDTH-1:0] word_adr;
   logic                  unused_lo;

   assign req      = wb_cyc_i & wb_stb_i;
   // Without error decode the upper address bits simply alias into the RAM.
   assign in_win   = ERR_ENABLE ? (wb_adr_i[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]) : 1'b1;
   assign word_adr = wb_adr_i[WIN_LSB-1:BYTE_BITS];
   // Byte offset within a word is irrelevant: lanes are chosen by wb_sel_i.
   assign unused_lo = ^wb_adr_i[BYTE_BITS-1:0];

   // State, latency counter, captured read address and read data registers.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         if (cap) begin
            dat_q <= ram_data_i;
         end
      end
   end

   // Next-state decode and RAM/bus strobes; ACK/ERR ignore req so terminations never run back-to-back.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      cap     = 1'b0;
      en_c    = 1'b0;
      wea_c   = '0;
      addr_c  = addr_q;
      ack_c   = 1'b0;
      err_c   = 1'b0;
      case (state_q)
         IDLE: begin
            addr_c = word_adr;
            if (req) begin
               if (!in_win) begin
                  state_d = ERR;
               end else if (wb_we_i) begin
                  en_c    = 1'b1;
                  wea_c   = wb_sel_i;
                  state_d = ACK;
               end else begin
                  en_c    = 1'b1;
                  addr_d  = word_adr;
                  cnt_d   = CNT_INIT;
                  state_d = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            en_c = 1'b1;
            if (!wb_cyc_i) begin
               state_d = IDLE;
            end else if (cnt_q != 2'd0) begin
               cnt_d = cnt_q - 2'd1;
            end else begin
               cap     = 1'b1;
               state_d = ACK;
            end
         end
         ACK: begin
            ack_c   = wb_cyc_i;
            state_d = IDLE;
         end
         ERR: begin
            err_c   = wb_cyc_i;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // RAM-side strobes are combinational from the bus, so they are forced quiet while reset is held.
   assign ram_en     = en_c & ~wb_rst_i;
   assign ram_wea    = wb_rst_i ? '0 : wea_c;
   assign ram_addr   = wb_rst_i ? '0 : addr_c;
   assign ram_data_o = wb_rst_i ? '0 : wb_dat_i;
   assign wb_ack_o   = ack_c;
   assign wb_err_o   = err_c;
   assign wb_dat_o   = dat_q;

endmodule

// File: doc/wb_bram_ctrl.md
Name: wb_bram_ctrl

Overview:
- Parametrised Wishbone classic slave that replaces the combinational BRAM bridge.
- Drives a synchronous block RAM with a configurable read latency (output pipeline registers) and registers both read data and termination.
- Decodes a base-address window and optionally terminates out-of-window accesses with wb_err_o.
- Sits between the system Wishbone interconnect and one BRAM instance.

Parameters:
DATA_WIDTH, 32, data bus width; multiple of 8; localparam SEL_W = DATA_WIDTH/8, BYTE_BITS = log2(SEL_W)
ADDR_WIDTH, 18, RAM word-address width (RAM depth = 2^ADDR_WIDTH words)
READ_LATENCY, 1, BRAM clock edges from address to valid ram_data_i; legal 1..3
BASE_ADDR, 32'h0000_0000, window base; aligned to window size 2^(ADDR_WIDTH+BYTE_BITS)
ERR_ENABLE, 1, 1: out-of-window access ends with wb_err_o; 0: upper address bits ignored (aliasing)

Ports:
wb_clk_i  in  1  clock; all logic on rising edge
wb_rst_i  in  1  reset, asynchronous, active-high
wb_cyc_i  in  1  bus cycle valid
wb_stb_i  in  1  strobe
wb_we_i  in  1  1 = write
wb_adr_i  in  32  byte address
wb_dat_i  in  DATA_WIDTH  write data
wb_sel_i  in  SEL_W  byte selects
wb_dat_o  out  DATA_WIDTH  registered read data
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination
ram_en  out  1  RAM port enable
ram_wea  out  SEL_W  per-byte write enable
ram_addr  out  ADDR_WIDTH  word address
ram_data_o  out  DATA_WIDTH  write data to RAM
ram_data_i  in  DATA_WIDTH  read data from RAM

Behaviour:
- Reset (async assert): state=IDLE, latency counter=0, wb_dat_o=0, ack/err registers=0. All outputs low/zero while reset is held.
- Reset mid-transfer aborts the transfer. A write already issued stays committed. No ack/err follows reset release.
- req = wb_cyc_i & wb_stb_i.
- in_win = (wb_adr_i[31:ADDR_WIDTH+BYTE_BITS] == BASE_ADDR[31:ADDR_WIDTH+BYTE_BITS]). When ERR_ENABLE=0, in_win is forced to 1.
- Word address = wb_adr_i[ADDR_WIDTH+BYTE_BITS-1:BYTE_BITS]. Low BYTE_BITS address bits are ignored.
- States: IDLE, RD_WAIT, ACK, ERR.
- IDLE, no req: ram_en=0, ram_wea=0, ram_addr=word address (don't-care).
- IDLE, req & in_win & we (write issue):
  - ram_en=1, ram_wea=wb_sel_i, ram_data_o=wb_dat_i, ram_addr=word address, all combinational in this cycle.
  - Next state ACK.
  - sel=0 still gives ack; no bytes are written.
- IDLE, req & in_win & !we (read issue):
  - ram_en=1, ram_wea=0, word address captured into addr_q.
  - counter loaded with READ_LATENCY-1; next state RD_WAIT.
- IDLE, req & !in_win: no RAM activity (ram_en=0, ram_wea=0); next state ERR.
- RD_WAIT:
  - ram_en=1, ram_addr=addr_q, ram_wea=0.
  - Counter nonzero: decrement.
  - Counter zero: capture ram_data_i into wb_dat_o, next state ACK.
  - Net effect: ack is high in cycle READ_LATENCY+1, counting the issue cycle as 0.
- ACK: wb_ack_o = wb_cyc_i. State returns to IDLE unconditionally. req is ignored in this cycle, so there is never back-to-back ack and at most one access per 2 cycles.
- ERR: wb_err_o = wb_cyc_i; then IDLE.
- wb_ack_o and wb_err_o are never high together. Each is at most one cycle per strobe.
- Write termination latency is 1 cycle; read termination latency is READ_LATENCY+1 cycles.
- Abort: wb_cyc_i low in RD_WAIT → IDLE immediately; no capture, wb_dat_o unchanged, no ack. wb_cyc_i low in ACK/ERR → termination suppressed; state still returns to IDLE.
- wb_dat_o holds its last captured value between reads and is not updated by writes.
- ram_addr outside IDLE is always addr_q. ram_data_o and ram_wea are only meaningful in the write-issue cycle.
- Boundaries:
  - Highest word 2^ADDR_WIDTH-1 is accessible.
  - The first byte beyond the window gives err (ERR_ENABLE=1) or aliases to word 0 (ERR_ENABLE=0).

Test Plan:
- Write then read, READ_LATENCY=1: write adr 0x10, dat 0xDEADBEEF, sel 4'hF → ram_wea=F and ram_addr=4 in cycle 0, ack in cycle 1. Read adr 0x10 → ack in cycle 2, wb_dat_o=0xDEADBEEF.
- Byte lanes: word 0x11223344 at adr 0x20, then write sel 4'b0010 dat 0xAABBCCDD → read returns 0x1122CC44.
- Latency sweep: READ_LATENCY=1,2,3 → read ack in cycle 2,3,4. ram_en stays high and ram_addr stable through RD_WAIT. Exactly one ack per read.
- Window error: BASE_ADDR=0x8000_0000, ADDR_WIDTH=10; access 0x8000_1000 → ram_en never high, wb_err_o in cycle 1, no ack. Same access with ERR_ENABLE=0 → access to word 0.
- Abort: READ_LATENCY=3, drop wb_cyc_i in cycle 2 → no ack/err, wb_dat_o unchanged. Next read completes normally.
- Reset mid-read: assert wb_rst_i asynchronously in RD_WAIT → all outputs 0 immediately. After release, stall 3 cycles with stb low → no ack. Then back-to-back writes (stb held high) → ack every 2nd cycle.
